// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with load/ready handshake,
// optional even-parity trailer and a one-cycle done pulse after each frame.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             x,
   output logic             x_valid,
   output logic             done,
   output logic [WIDTH-1:0] Q
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
   state_t         state;
   logic [CW-1:0]  cnt;
   logic           par;
   logic [WIDTH-1:0] nq;
   logic           nx;
   logic           lx;
   // x is registered, so it is taken from the transmit end of the next Q
   always_comb begin
      nq = MSB_FIRST ? {Q[WIDTH-2:0], 1'b0} : {1'b0, Q[WIDTH-1:1]};
      nx = MSB_FIRST ? nq[WIDTH-1] : nq[0];
      lx = MSB_FIRST ? din[WIDTH-1] : din[0];
   end
   always_ff @(posedge Clock) begin
      if (reset) begin
         state   <= IDLE;
         Q       <= '0;
         cnt     <= '0;
         par     <= 1'b0;
         x       <= 1'b0;
         x_valid <= 1'b0;
         ready   <= 1'b1;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (load) begin
                  state   <= SHIFT;
                  Q       <= din;
                  par     <= ^din;
                  cnt     <= '0;
                  x       <= lx;
                  x_valid <= 1'b1;
                  ready   <= 1'b0;
               end else begin
                  x       <= 1'b0;
                  x_valid <= 1'b0;
                  ready   <= 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == CW'(WIDTH - 1)) begin
                  Q <= '0;
                  if (PARITY_EN) begin
                     state <= PARITY;
                     x     <= par;
                  end else begin
                     state   <= IDLE;
                     x       <= 1'b0;
                     x_valid <= 1'b0;
                     ready   <= 1'b1;
                     done    <= 1'b1;
                  end
               end else begin
                  Q   <= nq;
                  x   <= nx;
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               x       <= 1'b0;
               x_valid <= 1'b0;
               ready   <= 1'b1;
               done    <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of MSB-first, LSB-first and parity
// instances, busy-load rejection, mid-frame reset and back-to-back frames.
module tb_piso_serializer;
   logic Clock = 1'b0;
   logic reset, load_a, load_b, load_c;
   logic [3:0] din;
   logic rd_a, x_a, v_a, d_a, rd_b, x_b, v_b, d_b, rd_c, x_c, v_c, d_c;
   logic [3:0] q_a, q_b, q_c;
   int checks = 0;
   int failures = 0;

   always #5 Clock = ~Clock;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_a (
      .Clock(Clock), .reset(reset), .load(load_a), .din(din),
      .ready(rd_a), .x(x_a), .x_valid(v_a), .done(d_a), .Q(q_a));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
      .Clock(Clock), .reset(reset), .load(load_b), .din(din),
      .ready(rd_b), .x(x_b), .x_valid(v_b), .done(d_b), .Q(q_b));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_c (
      .Clock(Clock), .reset(reset), .load(load_c), .din(din),
      .ready(rd_c), .x(x_c), .x_valid(v_c), .done(d_c), .Q(q_c));

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load_a = 1'b0; load_b = 1'b0; load_c = 1'b0; din = 4'b0000;
      tick();
      tick();
      checks++;
      if ({rd_a, x_a, v_a, d_a, q_a} !== 8'b1000_0000) begin
         failures++;
         $display("FAIL reset_a got rdy/x/v/done/Q=%b required 1000_0000", {rd_a, x_a, v_a, d_a, q_a});
      end
      checks++;
      if ({rd_b, x_b, v_b, d_b, q_b, rd_c, x_c, v_c, d_c, q_c} !== 16'b1000_0000_1000_0000) begin
         failures++;
         $display("FAIL reset_bc got %b required 1000000010000000",
                  {rd_b, x_b, v_b, d_b, q_b, rd_c, x_c, v_c, d_c, q_c});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_msb_first();
      logic [3:0] xs = 4'b1011;
      logic [15:0] qs = 16'b1011_0110_1100_1000;
      din = 4'b1011; load_a = 1'b1;
      tick();
      load_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({x_a, v_a, rd_a, d_a, q_a} !== {xs[3-i], 3'b100, qs[15-4*i -: 4]}) begin
            failures++;
            $display("FAIL msb_bit%0d got x/v/rdy/done/Q=%b required %b", i,
                     {x_a, v_a, rd_a, d_a, q_a}, {xs[3-i], 3'b100, qs[15-4*i -: 4]});
         end
         tick();
      end
      checks++;
      if ({d_a, rd_a, v_a, q_a} !== 7'b110_0000) begin
         failures++;
         $display("FAIL msb_done got done/rdy/v/Q=%b required 1100000", {d_a, rd_a, v_a, q_a});
      end
      tick();
      checks++;
      if ({d_a, rd_a, v_a} !== 3'b010) begin
         failures++;
         $display("FAIL msb_done_clear got done/rdy/v=%b required 010", {d_a, rd_a, v_a});
      end
   endtask

   task automatic test_lsb_first();
      logic [3:0] xs = 4'b1101;
      logic [15:0] qs = 16'b1011_0101_0010_0001;
      din = 4'b1011; load_b = 1'b1;
      tick();
      load_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({x_b, v_b, rd_b, q_b} !== {xs[3-i], 2'b10, qs[15-4*i -: 4]}) begin
            failures++;
            $display("FAIL lsb_bit%0d got x/v/rdy/Q=%b required %b", i,
                     {x_b, v_b, rd_b, q_b}, {xs[3-i], 2'b10, qs[15-4*i -: 4]});
         end
         tick();
      end
      checks++;
      if ({d_b, rd_b, v_b} !== 3'b110) begin
         failures++;
         $display("FAIL lsb_done got done/rdy/v=%b required 110", {d_b, rd_b, v_b});
      end
      tick();
   endtask

   task automatic test_parity(input logic [3:0] w, input logic p);
      din = w; load_c = 1'b1;
      tick();
      load_c = 1'b0;
      din = ~w;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({x_c, v_c, rd_c} !== {w[3-i], 2'b10}) begin
            failures++;
            $display("FAIL par_bit%0d din=%b got x/v/rdy=%b required %b", i, w,
                     {x_c, v_c, rd_c}, {w[3-i], 2'b10});
         end
         tick();
      end
      checks++;
      if ({x_c, v_c, rd_c, d_c, q_c} !== {p, 7'b100_0000}) begin
         failures++;
         $display("FAIL par_bit din=%b got x/v/rdy/done/Q=%b required %b", w,
                  {x_c, v_c, rd_c, d_c, q_c}, {p, 7'b100_0000});
      end
      tick();
      checks++;
      if ({d_c, rd_c, v_c} !== 3'b110) begin
         failures++;
         $display("FAIL par_done din=%b got done/rdy/v=%b required 110", w, {d_c, rd_c, v_c});
      end
      tick();
   endtask

   task automatic test_busy_load();
      logic [3:0] xs = 4'b1011;
      din = 4'b1011; load_a = 1'b1;
      tick();
      din = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) load_a = 1'b0;
         checks++;
         if ({x_a, v_a, rd_a} !== {xs[3-i], 2'b10}) begin
            failures++;
            $display("FAIL busy_bit%0d got x/v/rdy=%b required %b", i, {x_a, v_a, rd_a}, {xs[3-i], 2'b10});
         end
         tick();
      end
      checks++;
      if ({d_a, rd_a, v_a} !== 3'b110) begin
         failures++;
         $display("FAIL busy_done got done/rdy/v=%b required 110", {d_a, rd_a, v_a});
      end
      tick();
      checks++;
      if ({v_a, rd_a, d_a} !== 3'b010) begin
         failures++;
         $display("FAIL busy_no_queue got v/rdy/done=%b required 010", {v_a, rd_a, d_a});
      end
   endtask

   task automatic test_reset_mid_frame();
      int pulses = 0;
      din = 4'b1011; load_a = 1'b1;
      tick();
      load_a = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({x_a, v_a, q_a, rd_a, d_a} !== 8'b00_0000_10) begin
         failures++;
         $display("FAIL midreset got x/v/Q/rdy/done=%b required 00000010", {x_a, v_a, q_a, rd_a, d_a});
      end
      for (int i = 0; i < 6; i++) begin
         if (d_a === 1'b1 || v_a === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL midreset_quiet got active cycles=%0d required 0", pulses);
      end
      reset = 1'b1; load_a = 1'b1;
      tick();
      reset = 1'b0; load_a = 1'b0;
      checks++;
      if ({rd_a, v_a, x_a, d_a} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_load got rdy/v/x/done=%b required 1000", {rd_a, v_a, x_a, d_a});
      end
      tick();
      checks++;
      if ({rd_a, v_a} !== 2'b10) begin
         failures++;
         $display("FAIL reset_load_idle got rdy/v=%b required 10", {rd_a, v_a});
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] vs = 9'b11110_1111;
      logic [8:0] xs = 9'b01100_1001;
      int pulses = 0;
      din = 4'b0110; load_a = 1'b1;
      tick();
      load_a = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin
            din = 4'b1001; load_a = 1'b1;
         end else load_a = 1'b0;
         if (d_a === 1'b1) pulses++;
         checks++;
         if ({v_a, x_a} !== {vs[8-i], xs[8-i]}) begin
            failures++;
            $display("FAIL b2b_cycle%0d got v/x=%b required %b", i, {v_a, x_a}, {vs[8-i], xs[8-i]});
         end
         tick();
      end
      load_a = 1'b0;
      if (d_a === 1'b1) pulses++;
      tick();
      checks++;
      if (pulses !== 2) begin
         failures++;
         $display("FAIL b2b_done_pulses got %0d required 2", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_parity(4'b1011, 1'b1);
      test_parity(4'b0110, 1'b0);
      test_busy_load();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shift-register transmitter. It is the sending end for the lab's 4-bit serial-in shift register, which samples input x on each Clock edge and exposes Q[3:0].
- Accepts a WIDTH-bit word through a load/ready handshake and drives it one bit per clock on x, qualified by x_valid.
- Can append an even-parity bit after the data.
- Pulses done when the frame completes.

Parameters:
- WIDTH, 4: data word width in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- PARITY_EN, 0: 1 = append one even-parity bit after the last data bit.

Ports:
- Clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  request to start a frame; accepted only when sampled high with ready=1.
- din  input  WIDTH  word to transmit; sampled on the accepting edge only.
- ready  output  1  block is idle and can accept load.
- x  output  1  serial data out.
- x_valid  output  1  x carries a frame bit this cycle.
- done  output  1  one-cycle pulse after the final frame bit.
- Q  output  WIDTH  current shift-register contents (debug/observe).

Behaviour:
- Clock and reset: one clock, Clock. reset is synchronous and active-high. All outputs are registered.
- Reset values, taking effect at the first rising edge with reset=1: ready=1, x=0, x_valid=0, done=0, Q=0, state=IDLE, bit counter=0.
- Reset priority: reset overrides load and any frame in progress.
- States: IDLE, SHIFT, PARITY.
- IDLE:
  - Outputs: ready=1, x=0, x_valid=0.
  - load=1 sampled at edge n: capture din into Q and the parity accumulator. Clear the bit counter. Go to SHIFT.
  - In cycle n (the interval after edge n), drive the first bit on x with x_valid=1 and ready=0.
- SHIFT:
  - Bit i occupies cycle n+i, for i = 0..WIDTH-1.
  - Each edge shifts Q by one position toward the transmit end and zero-fills the vacated bit: left for MSB_FIRST=1, right for MSB_FIRST=0.
  - x is always the bit at the transmit end of Q.
  - At the edge ending bit WIDTH-1:
    - PARITY_EN=1: go to PARITY.
    - PARITY_EN=0: go to IDLE with done=1 for one cycle.
- PARITY:
  - Lasts one cycle (n+WIDTH).
  - x = XOR of all captured din bits, so total ones including parity are even. x_valid=1, Q=0.
  - Next edge: go to IDLE with done=1.
- Frame length: WIDTH cycles, plus 1 if PARITY_EN. done is high in the first IDLE cycle after the frame, alongside ready=1.
- Busy: load while ready=0 is ignored and does not queue. din changes mid-frame have no effect.
- Back-to-back frames: load may be accepted at the edge ending the done cycle. The minimum gap between frames is exactly one x_valid=0 cycle.
- Reset mid-frame: the frame is abandoned. After the edge, all outputs return to reset values, with no done pulse and no parity bit.
- Bit counter: ceil(log2(WIDTH+1)) bits. It never wraps within a frame.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, PARITY_EN=0. Load din=4'b1011 at edge n.
   - Cycles n..n+3: x=1,0,1,1 with x_valid=1 and ready=0.
   - Q = 1011, 0110, 1100, 1000.
   - Cycle n+4: done=1, ready=1, x_valid=0. Cycle n+5: done=0.
2. MSB_FIRST=0, din=4'b1011 → x=1,1,0,1 over four cycles, then done.
3. PARITY_EN=1, din=4'b1011 → x=1,0,1,1 then parity x=1 in cycle n+4, done in n+5. Repeat with din=4'b0110 → parity bit 0.
4. Ignored load: load din=4'b1111 at edge n+1 during the scenario-1 frame (din=4'b1011) → stream remains 1,0,1,1. No second frame starts; ready stays 0 until the done cycle.
5. Reset mid-frame: assert reset at edge n+2 of a 4'b1011 frame → from cycle n+2: x=0, x_valid=0, Q=0, ready=1, done=0, and done is never pulsed. Reset and load high together → stays IDLE.
6. Back-to-back: load 4'b0110, then load 4'b1001 at the edge ending the done cycle → x = 0,1,1,0, one idle cycle, then 1,0,0,1. done pulses twice.
